// File: rtl/rv_mem_pkg.sv
// Shared load-path definitions: funct3 load encodings, access-size decode and FSM states.
package rv_mem_pkg;

    // funct3 encodings of the integer load instructions
    localparam logic [2:0] OpLb  = 3'b000;
    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLw  = 3'b010;
    localparam logic [2:0] OpLd  = 3'b011;
    localparam logic [2:0] OpLbu = 3'b100;
    localparam logic [2:0] OpLhu = 3'b101;
    localparam logic [2:0] OpLwu = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StRd0,
        StRd1,
        StResp
    } load_state_t;

    // Access size in bytes from funct3[1:0]: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    // 3'b111 never exists; doubleword and LWU only exist when XLEN is 64.
    function automatic logic op_illegal(input logic [2:0] op, input int unsigned xlen);
        return (op == 3'b111) || ((xlen == 32) && ((op == OpLd) || (op == OpLwu)));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load result formatter: shifts the addressed bytes of a two-word window down to bit 0,
// trims them to the access size and sign- or zero-extends to XLEN.
module load_extend #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] data,
    input  logic [OFF_W-1:0]  offset,
    input  logic [2:0]        op,
    output logic [XLEN-1:0]   result
);
    import rv_mem_pkg::*;

    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   low;
    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   top_bit;
    logic              sign_bit;
    logic              sign_ext;
    int                nbits;

    // Align, mask to the access width, then fill the upper bits with sign or zero.
    always_comb begin
        shifted = data >> {offset, 3'b000};
        low     = shifted[XLEN-1:0];
        nbits   = 8 * int'(size_bytes(op[1:0]));
        if (nbits > int'(XLEN)) begin
            nbits = int'(XLEN);
        end
        mask = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            mask[i] = (i < nbits);
        end
        // Highest set bit of the mask marks the sign position of the loaded value.
        top_bit  = mask ^ (mask >> 1);
        sign_bit = |(low & top_bit);
        // Unsigned variants have op[2] set; a full-width load has nothing to extend.
        sign_ext = ~op[2] & (op[1:0] != 2'b11);
        result   = (low & mask) | ({XLEN{sign_ext & sign_bit}} & ~mask);
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: accepts one load at a time, issues word-aligned reads to the data
// memory and returns the extended result or a fault on a valid/ready channel.
// Build option: define MISALIGN_SPLIT_EN to execute misaligned loads (splitting
// word-crossing ones into two reads); otherwise misaligned loads fault.
module load_align_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [2:0]        ld_op,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_fault
);
    import rv_mem_pkg::*;

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    load_state_t       state_q, state_d;
    logic [2:0]        op_q;
    logic [OFF_W-1:0]  offset_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              rsp_fault_q;

    logic [OFF_W-1:0]  req_offset;
    logic [3:0]        req_size;
    logic [ADDR_W-1:0] req_aligned;
    logic              req_fault;
    logic              accept;
    logic              final_ack;
    logic [2*XLEN-1:0] ext_in;
    logic [XLEN-1:0]   ext_data;
`ifdef MISALIGN_SPLIT_EN
    logic              req_cross;
    logic              cross_q;
    logic [XLEN-1:0]   lo_q;
`else
    logic [3:0]        size_m1;
`endif

    // Decode the request presented in IDLE: offset, size, aligned address, fault.
    always_comb begin
        req_offset  = ld_addr[OFF_W-1:0];
        req_size    = size_bytes(ld_op[1:0]);
        req_aligned = {ld_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        accept      = ld_valid & (state_q == StIdle);
`ifdef MISALIGN_SPLIT_EN
        req_fault = op_illegal(ld_op, XLEN);
        req_cross = (5'(req_offset) + 5'(req_size)) > 5'(BYTES);
`else
        size_m1   = req_size - 4'd1;
        req_fault = op_illegal(ld_op, XLEN) || ((req_offset & size_m1[OFF_W-1:0]) != '0);
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ld_valid) begin
                    state_d = req_fault ? StResp : StRd0;
                end
            end
            StRd0: begin
                if (mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
                    state_d = cross_q ? StRd1 : StResp;
`else
                    state_d = StResp;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            StRd1: begin
                if (mem_ack) begin
                    state_d = StResp;
                end
            end
`endif
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the current state and the datapath registers.
    always_comb begin
        ld_ready  = (state_q == StIdle);
        mem_req   = (state_q == StRd0) || (state_q == StRd1);
        rsp_valid = (state_q == StResp);
        mem_addr  = mem_addr_q;
        rsp_data  = rsp_data_q;
        rsp_fault = rsp_fault_q;
    end

    // Build the two-word window for the formatter and flag the read that completes the load.
    // The last beat is fed straight from the bus so the result registers on that ack.
    always_comb begin
        final_ack = 1'b0;
        ext_in    = {{XLEN{1'b0}}, mem_rdata};
        unique case (state_q)
            StRd0: begin
`ifdef MISALIGN_SPLIT_EN
                final_ack = mem_ack & ~cross_q;
`else
                final_ack = mem_ack;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            StRd1: begin
                final_ack = mem_ack;
                ext_in    = {mem_rdata, lo_q};
            end
`endif
            default: final_ack = 1'b0;
        endcase
    end

    load_extend #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_extend (
        .data   (ext_in),
        .offset (offset_q),
        .op     (op_q),
        .result (ext_data)
    );

    // Request latch, read address sequencing and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            offset_q    <= '0;
            mem_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            cross_q     <= 1'b0;
            lo_q        <= '0;
`endif
        end else begin
            if (accept) begin
                op_q        <= ld_op;
                offset_q    <= req_offset;
                rsp_fault_q <= req_fault;
`ifdef MISALIGN_SPLIT_EN
                cross_q     <= req_cross;
`endif
                if (req_fault) begin
                    rsp_data_q <= '0;
                end else begin
                    mem_addr_q <= req_aligned;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            if ((state_q == StRd0) && mem_ack) begin
                lo_q <= mem_rdata;
                // Second word wraps silently at the top of the address space.
                if (cross_q) begin
                    mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
                end
            end
`endif
            if (final_ack) begin
                rsp_data_q <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit (XLEN=32): directed cases plus randomized loads, checked by a
// scoreboard against a byte-addressed memory model. Honors MISALIGN_SPLIT_EN.
module tb_load_align_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam int NUM_RANDOM = 400;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            fault;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [2:0]        ld_op;
    logic [ADDR_W-1:0] ld_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_fault;

    rsp_t              exp_rsp_q[$];
    logic [31:0]       exp_addr_q[$];
    logic [7:0]        mem_bytes[logic [31:0]];
    int                vectors = 0;
    int                miscompares = 0;
    int                ack_mode = 0;  // 0 normal, 1 never ack, 2 ack every cycle

    always #5 clk = ~clk;

    load_align_unit #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_op     (ld_op),
        .ld_addr   (ld_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] h;
        if (mem_bytes.exists(a)) return mem_bytes[a];
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[15:8];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_bytes[a + 32'(i)] = w[8*i +: 8];
    endtask

    function automatic rsp_t mk(input logic [31:0] d, input logic f);
        rsp_t r;
        r.data  = d;
        r.fault = f;
        return r;
    endfunction

    // Reference: gather the addressed bytes little-endian and extend by the op's signedness.
    function automatic rsp_t model(input logic [2:0] op, input logic [31:0] addr);
        rsp_t        r;
        int          size;
        logic [63:0] val;
        bit          illegal;
        bit          misal;
        size    = 1 << op[1:0];
        illegal = (op == 3'b111) || (op == 3'b011) || (op == 3'b110);
        misal   = (addr % 32'(size)) != 0;
        r.fault = illegal || (!SPLIT && misal);
        r.data  = '0;
        if (!r.fault) begin
            val = '0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = byte_at(addr + 32'(i));
            if (!op[2] && val[8*size-1]) begin
                for (int b = 8 * size; b < 64; b++) val[b] = 1'b1;
            end
            r.data = val[31:0];
        end
        return r;
    endfunction

    // Issue one load once the unit is ready; junk requests are driven while it is busy.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input rsp_t exp);
        int          guard;
        int          size;
        logic [31:0] aligned;
        guard = 0;
        while (!ld_ready) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_op    = 3'($urandom_range(0, 7));
            ld_addr  = $urandom;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL ld_ready_timeout: ld_ready=%0b after %0d cycles, expected 1", ld_ready, guard);
                return;
            end
        end
        ld_valid = 1'b1;
        ld_op    = op;
        ld_addr  = addr;
        size     = 1 << op[1:0];
        aligned  = addr & 32'hFFFF_FFFC;
        exp_rsp_q.push_back(exp);
        if (!exp.fault) begin
            exp_addr_q.push_back(aligned);
            if (SPLIT && ((int'(addr % 32'd4) + size) > 4)) exp_addr_q.push_back(aligned + 32'd4);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_op    = 3'($urandom_range(0, 7));
        ld_addr  = $urandom;
        check("ready_drop", 64'(ld_ready), 64'd0);
        if (exp.fault) begin
            check("fault_rsp_latency", 64'(rsp_valid), 64'd1);
            check("fault_no_req", 64'(mem_req), 64'd0);
        end else begin
            check("req_latency", 64'(mem_req), 64'd1);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_rsp_q.size() != 0) && (guard < 500)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_rsp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_rsp_q.size());
        end
    endtask

    // Memory responder: random ack delay per request, stray acks while idle.
    initial begin
        int  wait_cnt;
        bit  busy;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        busy      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end else if (mem_req && (ack_mode == 0)) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word_at(mem_addr);
                    busy      = 1'b0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    wait_cnt--;
                end
            end else begin
                busy      = 1'b0;
                mem_ack   = (ack_mode == 0) && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Consumer back-pressure.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: read addresses, response latency, hold stability and response contents.
    initial begin
        bit          expect_valid;
        bit          stall;
        logic [31:0] held_data;
        logic        held_fault;
        rsp_t        e;
        expect_valid = 1'b0;
        stall        = 1'b0;
        held_data    = '0;
        held_fault   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expect_valid = 1'b0;
                stall        = 1'b0;
            end else begin
                if (expect_valid) begin
                    check("rsp_after_final_ack", 64'(rsp_valid), 64'd1);
                    expect_valid = 1'b0;
                end
                if (mem_req) begin
                    if (exp_addr_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_mem_req: mem_req=1 addr=0x%0h, expected no read", mem_addr);
                    end else begin
                        check("mem_addr", 64'(mem_addr), 64'(exp_addr_q[0]));
                        if (mem_ack) begin
                            void'(exp_addr_q.pop_front());
                            if (exp_addr_q.size() == 0) expect_valid = 1'b1;
                        end
                    end
                end
                if (rsp_valid) begin
                    if (stall) begin
                        check("rsp_hold_data", 64'(rsp_data), 64'(held_data));
                        check("rsp_hold_fault", 64'(rsp_fault), 64'(held_fault));
                    end
                    if (rsp_ready) begin
                        stall = 1'b0;
                        if (exp_rsp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_rsp: data=0x%0h fault=%0b, expected none", rsp_data, rsp_fault);
                        end else begin
                            e = exp_rsp_q.pop_front();
                            check("rsp_data", 64'(rsp_data), 64'(e.data));
                            check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
                            check("reads_done", 64'(exp_addr_q.size()), 64'd0);
                        end
                    end else begin
                        stall      = 1'b1;
                        held_data  = rsp_data;
                        held_fault = rsp_fault;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_op    = '0;
        ld_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ld_ready", 64'(ld_ready), 64'd1);
        check("reset_mem_req", 64'(mem_req), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_rsp_fault", 64'(rsp_fault), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with hand-computed expectations.
        put_word(32'h100, 32'h80AA_BBCC);
        issue(3'b000, 32'h103, mk(32'hFFFF_FF80, 1'b0));
        put_word(32'h200, 32'h9ABC_1234);
        issue(3'b101, 32'h202, mk(32'h0000_9ABC, 1'b0));
        put_word(32'hFFC, 32'h1122_3344);
        put_word(32'h1000, 32'h5566_7788);
        issue(3'b010, 32'hFFE, SPLIT ? mk(32'h7788_1122, 1'b0) : mk(32'h0, 1'b1));
        issue(3'b011, 32'h0, mk(32'h0, 1'b1));
        issue(3'b111, 32'h8, mk(32'h0, 1'b1));
        issue(3'b110, 32'h10, mk(32'h0, 1'b1));
        put_word(32'h300, 32'h8001_7FFF);
        issue(3'b001, 32'h302, mk(32'hFFFF_8001, 1'b0));
        issue(3'b001, 32'h300, mk(32'h0000_7FFF, 1'b0));
        issue(3'b100, 32'h301, mk(32'h0000_007F, 1'b0));
        issue(3'b000, 32'h303, mk(32'hFFFF_FF80, 1'b0));
        issue(3'b010, 32'h300, mk(32'h8001_7FFF, 1'b0));
        issue(3'b101, 32'h302, mk(32'h0000_8001, 1'b0));
        issue(3'b001, 32'h301, SPLIT ? mk(32'h0000_017F, 1'b0) : mk(32'h0, 1'b1));

        // Randomized loads against the model.
        for (int n = 0; n < NUM_RANDOM; n++) begin
            logic [2:0]  op;
            logic [31:0] addr;
            int          size;
            op   = 3'($urandom_range(0, 7));
            size = 1 << op[1:0];
            case ($urandom_range(0, 3))
                0:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       addr = 32'h0000_0FF0 + 32'($urandom_range(0, 31));
                default: addr = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'(size - 1);
            issue(op, addr, model(op, addr));
        end
        drain();
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a read, then stray acks after release.
        ack_mode = 1;
        issue(3'b010, 32'h400, model(3'b010, 32'h400));
        @(posedge clk);
        #1;
        check("rst_pre_req", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ld_ready", 64'(ld_ready), 64'd1);
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_data", 64'(rsp_data), 64'd0);
        check("midrst_rsp_fault", 64'(rsp_fault), 64'd0);
        exp_rsp_q.delete();
        exp_addr_q.delete();
        ack_mode = 2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("late_ack_no_req", 64'(mem_req), 64'd0);
            check("late_ack_no_valid", 64'(rsp_valid), 64'd0);
            check("late_ack_ready", 64'(ld_ready), 64'd1);
        end
        ack_mode = 0;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised load-data unit between the core's memory stage and the data-memory port, for XLEN 32 or 64.
- Accepts one load (op, byte address) at a time and issues one or two word-aligned memory reads.
- Extracts the addressed byte/half/word/double from the returned data, then zero- or sign-extends it to XLEN.
- Returns the result, or a fault, on a valid/ready response channel.

Parameters:
- XLEN, 32, data width; legal values 32 or 64. BYTES = XLEN/8.
- ADDR_W, 32, byte-address width.

Ports:
- Clk  in  1  clock
- Rst_N  in  1  reset, asynchronous, active-low
- Ld_Valid  in  1  load request valid
- Ld_Ready  out  1  unit can accept a request
- Ld_Op  in  3  funct3: LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110
- Ld_Addr  in  ADDR_W  byte address
- Mem_Req  out  1  memory read request
- Mem_Addr  out  ADDR_W  word-aligned read address (low log2(BYTES) bits zero)
- Mem_Ack  in  1  read data valid this cycle
- Mem_Rdata  in  XLEN  read data
- Rsp_Valid  out  1  response valid
- Rsp_Ready  in  1  consumer accepts response
- Rsp_Data  out  XLEN  extended load result
- Rsp_Fault  out  1  misaligned-unsupported or illegal op

Behaviour:
- Clock/reset (already decided): one clock, Clk; reset Rst_N is asynchronous, active-low.
- Reset values: state IDLE; Ld_Ready=1; Mem_Req=0; Mem_Addr=0; Rsp_Valid=0; Rsp_Data=0; Rsp_Fault=0.
- States: IDLE, RD0, RD1, RESP.
- IDLE:
  - Ld_Ready=1. On Ld_Valid & Ld_Ready, latch op, addr and offset = addr mod BYTES.
  - Size: 1/2/4/8 bytes by op[1:0].
  - Illegal ops: 111 always; LD/LWU when XLEN=32. Go to RESP with Rsp_Fault=1, Rsp_Data=0; no memory access.
  - Otherwise go to RD0 with Mem_Addr = aligned addr.
- RD0:
  - Mem_Req=1, held with Mem_Addr stable until Mem_Ack. Mem_Ack is sampled only while Mem_Req=1; Ack in the first Req cycle is legal.
  - On Ack, capture Mem_Rdata into lo.
  - If offset+size > BYTES (crosses word), go to RD1. Otherwise go to RESP.
- RD1:
  - Mem_Addr = aligned addr + BYTES, modulo 2^ADDR_W (wrap at top of address space is legal).
  - On Ack, capture Mem_Rdata into hi, go to RESP.
- Merge and extend:
  - Merge: take {hi,lo} >> (offset*8) and keep the low size bytes. Single-read case uses hi=0.
  - Extend: LB/LH/LW sign-extend to XLEN. LBU/LHU/LWU zero-extend. LD passes through.
  - Extension is combinational from captured data; the result is registered into Rsp_Data on the final Ack.
- RESP:
  - Rsp_Valid=1; Rsp_Data and Rsp_Fault held stable until Rsp_Ready.
  - On Rsp_Valid & Rsp_Ready, return to IDLE. Ld_Ready rises the next cycle (no same-cycle re-accept).
- Latency:
  - Accept cycle N. Mem_Req from N+1.
  - Rsp_Valid at the cycle after the final Ack.
  - Minimum 3 cycles for aligned, 4 for split, with zero-wait ack.
- Ld_Valid outside IDLE is ignored. Mem_Ack outside RD0/RD1 is ignored.
- Rst_N low mid-transaction: immediate return to reset values; the transaction is dropped. A late Mem_Ack after reset is ignored.
- Alignment rule, default build (feature off): any access with offset not a multiple of size faults in IDLE; no memory access, Rsp_Fault=1, Rsp_Data=0.

Optional Feature:
- MISALIGN_SPLIT_EN defined:
  - Misaligned accesses are executed, not faulted.
  - Accesses wholly within one word use RD0 only.
  - Word-crossing accesses use RD0 then RD1 and are merged.
- Undefined:
  - RD1 is unreachable and removed.
  - Misaligned access returns Rsp_Fault=1.

Decomposition:
- Shared package rv_mem_pkg holds:
  - load op constants (LB..LWU funct3 codes);
  - size decode function;
  - state enum typedef.
- Sub-module load_extend: combinational select/shift plus sign/zero extension. Parametrised by XLEN; inputs {hi,lo}, offset, op; output XLEN data.

Test Plan:
- XLEN=32, LB at 0x103, Mem_Rdata=0x80AA_BBCC, ack in first Req cycle -> Mem_Addr=0x100; Rsp_Data=0xFFFF_FF80, Fault=0; Rsp_Valid 3 cycles after accept.
- XLEN=32, LHU at 0x202, Rdata=0x9ABC_1234, Mem_Ack delayed 3 cycles, Rsp_Ready low 2 cycles -> Mem_Req held 4 cycles; Rsp_Data=0x0000_9ABC held stable until Ready.
- XLEN=32, MISALIGN_SPLIT_EN defined, LW at 0x0FFE, words 0x1122_3344 @0x0FFC and 0x5566_7788 @0x1000 -> two reqs; Rsp_Data=0x7788_1122.
- Same LW at 0x0FFE without the macro -> no Mem_Req; Rsp_Fault=1, Rsp_Data=0. Also LD with XLEN=32 -> Fault=1.
- XLEN=64, LWU at 0x14, Rdata=0xDEAD_BEEF_0000_0001 -> Mem_Addr=0x10; Rsp_Data=0x0000_0000_DEAD_BEEF. LW with the same data -> 0xFFFF_FFFF_DEAD_BEEF.
- Rst_N low while in RD0 with Mem_Req=1; Mem_Ack pulses after release -> all outputs at reset values, Ld_Ready=1, no Rsp_Valid generated.
